// File: rtl/dma_wr_pkg.sv
// Shared types and helpers for the DMA write-side burst master.
package dma_wr_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALC      = 2'd1,
    WAIT_DATA = 2'd2,
    BURST     = 2'd3
  } wr_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

  // Beats up to the next MAX_BURST-aligned word boundary, clipped to what is left.
  function automatic int unsigned calc_burst_len(input int unsigned word_addr_lsbs,
                                                 input int unsigned remaining,
                                                 input int unsigned max_burst);
    int unsigned room;
    room = max_burst - (word_addr_lsbs % max_burst);
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/dma_wr_burst_calc.sv
// Combinational burst length: stop at the next MAX_BURST boundary or at the end of the transfer.
module dma_wr_burst_calc
  import dma_wr_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned OFS_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  parameter int unsigned BC_WIDTH  = $clog2(MAX_BURST) + 1
) (
  input  logic [OFS_WIDTH-1:0] addr_lsbs_i,
  input  logic [LEN_WIDTH-1:0] remaining_i,
  output logic [BC_WIDTH-1:0]  burst_len_c
);

  // Result always fits: it is bounded by MAX_BURST.
  always_comb begin
    burst_len_c = BC_WIDTH'(calc_burst_len(32'(addr_lsbs_i), 32'(remaining_i), MAX_BURST));
  end

endmodule

// File: rtl/dma_wr_burst_master.sv
// Avalon-MM burst write master: splits a command into boundary-aligned bursts,
// starting each burst only once the FIFO already holds all of its words.
module dma_wr_burst_master
  import dma_wr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned BC_WIDTH   = $clog2(MAX_BURST) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  output logic                    fifo_rd_o,
  input  logic [DATA_WIDTH-1:0]   fifo_data_i,
  input  logic [FIFO_AW:0]        fifo_used_i,
  input  logic                    fifo_empty_i,
  output logic [ADDR_WIDTH-1:0]   avm_address_o,
  output logic                    avm_write_o,
  output logic [DATA_WIDTH-1:0]   avm_writedata_o,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable_o,
  output logic [BC_WIDTH-1:0]     avm_burstcount_o,
  input  logic                    avm_waitrequest_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned BPW       = DATA_WIDTH / 8;
  localparam int unsigned BPW_LOG2  = $clog2(BPW);
  localparam int unsigned WA_WIDTH  = ADDR_WIDTH - BPW_LOG2;
  localparam int unsigned OFS_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned CMP_WIDTH = (FIFO_AW + 1 > BC_WIDTH) ? FIFO_AW + 1 : BC_WIDTH;

  wr_state_t             state_q, state_d;
  logic [WA_WIDTH-1:0]   word_addr_q, word_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [BC_WIDTH-1:0]   burst_len_q, burst_len_d;
  logic [BC_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  done_q, done_d;
  logic [BC_WIDTH-1:0]   calc_len_c;
  logic                  beat_acc_c;
  logic                  last_beat_c;

  // Byte-offset bits of the command address and the FIFO empty flag carry no information here.
  logic unused_ok;
  assign unused_ok = ^{cmd_addr_i[BPW_LOG2-1:0], fifo_empty_i};

  dma_wr_burst_calc #(
    .LEN_WIDTH (LEN_WIDTH),
    .MAX_BURST (MAX_BURST),
    .OFS_WIDTH (OFS_WIDTH),
    .BC_WIDTH  (BC_WIDTH)
  ) u_calc (
    .addr_lsbs_i (word_addr_q[OFS_WIDTH-1:0]),
    .remaining_i (rem_q),
    .burst_len_c (calc_len_c)
  );

  // Next state, address/length bookkeeping and beat counting.
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    rem_d       = rem_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    done_d      = 1'b0;
    beat_acc_c  = (state_q == BURST) && !avm_waitrequest_i;
    last_beat_c = beat_acc_c && (beat_cnt_q == burst_len_q - BC_WIDTH'(1));

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          word_addr_d = cmd_addr_i[ADDR_WIDTH-1:BPW_LOG2];
          rem_d       = cmd_len_i;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        burst_len_d = calc_len_c;
        beat_cnt_d  = '0;
        state_d     = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (CMP_WIDTH'(fifo_used_i) >= CMP_WIDTH'(burst_len_q)) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat_acc_c) begin
          beat_cnt_d = beat_cnt_q + BC_WIDTH'(1);
        end
        if (last_beat_c) begin
          word_addr_d = word_addr_q + WA_WIDTH'(burst_len_q);
          rem_d       = rem_q - LEN_WIDTH'(burst_len_q);
          beat_cnt_d  = '0;
          if (rem_q == LEN_WIDTH'(burst_len_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      rem_q       <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      rem_q       <= rem_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign avm_write_o      = (state_q == BURST);
  assign avm_address_o    = ADDR_WIDTH'(word_addr_q) << BPW_LOG2;
  assign avm_burstcount_o = burst_len_q;
  assign avm_byteenable_o = '1;
  assign avm_writedata_o  = fifo_data_i;
  assign fifo_rd_o        = beat_acc_c;

endmodule

// File: tb/tb_dma_wr_burst_master.sv
// Scoreboard bench for dma_wr_burst_master with a behavioural show-ahead FIFO.
module tb_dma_wr_burst_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  bc;
    logic [31:0] data;
    logic [4:0]  idx;
  } beat_t;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_len_i;
  logic        fifo_rd_o;
  logic [31:0] fifo_data_i;
  logic [4:0]  fifo_used_i;
  logic        fifo_empty_i;
  logic [31:0] avm_address_o;
  logic        avm_write_o;
  logic [31:0] avm_writedata_o;
  logic [3:0]  avm_byteenable_o;
  logic [4:0]  avm_burstcount_o;
  logic        avm_waitrequest_i;
  logic        busy_o;
  logic        done_o;

  dma_wr_burst_master dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .cmd_valid_i       (cmd_valid_i),
    .cmd_ready_o       (cmd_ready_o),
    .cmd_addr_i        (cmd_addr_i),
    .cmd_len_i         (cmd_len_i),
    .fifo_rd_o         (fifo_rd_o),
    .fifo_data_i       (fifo_data_i),
    .fifo_used_i       (fifo_used_i),
    .fifo_empty_i      (fifo_empty_i),
    .avm_address_o     (avm_address_o),
    .avm_write_o       (avm_write_o),
    .avm_writedata_o   (avm_writedata_o),
    .avm_byteenable_o  (avm_byteenable_o),
    .avm_burstcount_o  (avm_burstcount_o),
    .avm_waitrequest_i (avm_waitrequest_i),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Written only by the stimulus process.
  beat_t sb[$];
  int    exp_idx    = 0;
  int    prod_total = 0;
  int    prod_cap   = 16;
  bit    stall_en   = 0;
  int    flush_cnt  = 0;
  int    acc_edge   = 0;

  // Written only by the monitor process.
  logic [31:0] fq[$];
  int    sb_rd      = 0;
  int    prod_done  = 0;
  int    flush_seen = 0;
  bit    pend_pop   = 0;
  bit    exp_more   = 0;
  bit    stall_prev = 0;
  bit    write_prev = 0;
  int    beats_acc  = 0;
  int    last_edge  = 0;
  int    rise_cyc   = 0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic [4:0]  prev_bc;

  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model, waitrequest driver and beat checker.
  always @(negedge clk) begin
    beat_t e;
    bit    acc;
    if (flush_cnt != flush_seen) begin
      fq.delete();
      sb_rd      = sb.size();
      prod_done  = prod_total;
      flush_seen = flush_cnt;
      pend_pop   = 0;
      exp_more   = 0;
      stall_prev = 0;
      write_prev = 0;
    end else if (pend_pop) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pend_pop = 0;
    end
    if (prod_done < prod_total && fq.size() < prod_cap) begin
      fq.push_back(32'hC0DE_0000 + 32'(prod_done));
      prod_done++;
    end
    fifo_used_i       = 5'(fq.size());
    fifo_empty_i      = (fq.size() == 0);
    fifo_data_i       = (fq.size() > 0) ? fq[0] : 32'h0;
    avm_waitrequest_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if (!rst_i) begin
      acc = avm_write_o && !avm_waitrequest_i;
      if (avm_write_o || fifo_rd_o) check_eq("fifo_rd", 64'(fifo_rd_o), 64'(acc));
      if (exp_more) check_eq("write_held", 64'(avm_write_o), 64'd1);
      if (stall_prev && avm_write_o) begin
        check_eq("stall_addr", 64'(avm_address_o), 64'(prev_addr));
        check_eq("stall_bc", 64'(avm_burstcount_o), 64'(prev_bc));
        check_eq("stall_data", 64'(avm_writedata_o), 64'(prev_data));
      end
      if (avm_write_o && !write_prev) begin
        rise_cyc = cyc;
        check_eq("no_bubble", 64'(fifo_used_i >= avm_burstcount_o), 64'd1);
      end
      exp_more = 0;
      if (avm_write_o) begin
        if (sb_rd >= sb.size()) begin
          check_eq("spurious_write", 64'(avm_write_o), 64'd0);
        end else begin
          e = sb[sb_rd];
          exp_more = !(acc && (e.idx == e.bc - 5'd1));
          if (acc) begin
            check_eq("beat_addr", 64'(avm_address_o), 64'(e.addr));
            check_eq("beat_bc", 64'(avm_burstcount_o), 64'(e.bc));
            check_eq("beat_data", 64'(avm_writedata_o), 64'(e.data));
            if (fq.size() == 0) check_eq("underflow", 64'(fq.size()), 64'd1);
            sb_rd++;
            pend_pop  = 1;
            beats_acc++;
            last_edge = cyc + 1;
          end
        end
      end
      stall_prev = avm_write_o && avm_waitrequest_i;
      write_prev = avm_write_o;
      prev_addr  = avm_address_o;
      prev_bc    = avm_burstcount_o;
      prev_data  = avm_writedata_o;
    end
  end

  task automatic give_data(input int len);
    prod_total += len;
  endtask

  // Push the expected beats of a command, then present it for one accepting edge.
  task automatic do_cmd(input logic [31:0] addr, input int len);
    int unsigned wa;
    int r;
    int b;
    int room;
    beat_t e;
    wa = addr >> 2;
    r  = len;
    while (r > 0) begin
      room = 16 - int'(wa % 16);
      b    = (r < room) ? r : room;
      for (int k = 0; k < b; k++) begin
        e.addr = 32'(wa << 2);
        e.bc   = 5'(b);
        e.data = 32'hC0DE_0000 + 32'(exp_idx);
        e.idx  = 5'(k);
        sb.push_back(e);
        exp_idx++;
      end
      wa += 32'(b);
      r  -= b;
    end
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_len_i   = 16'(len);
    #1;
    check_eq("cmd_ready", 64'(cmd_ready_o), 64'd1);
    @(posedge clk);
    #1;
    acc_edge    = cyc;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = 32'hDEAD_BEEF;
    cmd_len_i   = 16'h7;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit zero_len);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #2;
      if (done_o) begin
        seen = 1;
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
        check_eq({tag, "_sb_left"}, 64'(sb.size() - sb_rd), 64'd0);
        check_eq({tag, "_done_edge"}, 64'(cyc), zero_len ? 64'(acc_edge) : 64'(last_edge));
      end
    end
    check_eq({tag, "_timeout"}, 64'(seen), 64'd1);
    @(negedge clk);
    #2;
    check_eq({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
    check_eq({tag, "_write"}, 64'(avm_write_o), 64'd0);
    check_eq({tag, "_addr"}, 64'(avm_address_o), 64'd0);
    check_eq({tag, "_bc"}, 64'(avm_burstcount_o), 64'd0);
    check_eq({tag, "_rd"}, 64'(fifo_rd_o), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_eq({tag, "_done"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int base;
    bit hit;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = 32'h0;
    cmd_len_i   = 16'h0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_vals("rst");
    check_eq("rst_byteen", 64'(avm_byteenable_o), 64'hF);
    @(negedge clk);
    rst_i = 1'b0;

    // 1: single aligned 16-beat burst from a prefilled FIFO
    give_data(16);
    repeat (20) @(negedge clk);
    do_cmd(32'h0000_1000, 16);
    wait_done("t1", 100, 0);
    check_eq("t1_latency", 64'(rise_cyc - acc_edge), 64'd2);

    // 2: unaligned start, three bursts
    give_data(40);
    do_cmd(32'h0000_1008, 40);
    wait_done("t2", 300, 0);

    // 3: same transfer under random stalls
    stall_en = 1;
    give_data(40);
    do_cmd(32'h0000_1008, 40);
    wait_done("t3", 1000, 0);
    stall_en = 0;

    // 4: only 5 words available, burst of 16 must wait for the rest
    prod_cap = 5;
    give_data(16);
    do_cmd(32'h0000_4000, 16);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #2;
      check_eq("t4_hold", 64'(avm_write_o), 64'd0);
    end
    prod_cap = 16;
    wait_done("t4", 200, 0);

    // 5: zero-length command
    do_cmd(32'h0000_5000, 0);
    wait_done("t5", 3, 1);

    // 6: reset in the middle of a burst, then a fresh short command
    give_data(16);
    repeat (20) @(negedge clk);
    base = beats_acc;
    do_cmd(32'h0000_2000, 16);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (beats_acc >= base + 7) hit = 1;
    end
    check_eq("t6_reach_beat7", 64'(hit), 64'd1);
    rst_i = 1'b1;
    flush_cnt++;
    #1;
    check_reset_vals("t6_rst");
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    give_data(4);
    repeat (6) @(negedge clk);
    do_cmd(32'h0000_3004, 4);
    wait_done("t6", 100, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
